fir_coeff_axil_slave: RTL and testbench
=======================================

# fir_coeff_axil_slave

AXI4-Lite write-only responder that terminates the coefficient bus driven by the MicroBlaze subsystem and presents a double-buffered 5x5 coefficient set, plus output shift, to the 2D FIR datapath. The CPU writes a shadow bank. A commit request copies the shadow bank into the active bank only at the next frame start, so a frame is never filtered with a mix of old and new taps. Sits between the MicroBlaze M03 AXI-Lite port and the systolic convolution core, in the same clock domain as the write bus.

## Interface
- COEFF_W, 16: signed coefficient width; 2..32.
- SHIFT_W, 5: width of the output right-shift field.
- SHIFT_RST, 8: reset shift value; the reset centre tap is 1<<SHIFT_RST, which must fit in COEFF_W-1 bits.

Ports:
- clk  in  1  bus and register clock.
- rstn  in  1  asynchronous, active-low reset.
- s_axi_awaddr  in  32  write address; byte address, bits [1:0] ignored.
- s_axi_awvalid  in  1  address valid.
- s_axi_awready  out  1  address accepted.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte-lane enables.
- s_axi_wvalid  in  1  data valid.
- s_axi_wready  out  1  data accepted.
- s_axi_bresp  out  2  response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_bvalid  out  1  response valid.
- s_axi_bready  in  1  response accepted.
- frame_start_i  in  1  one-cycle pulse at the first pixel of a frame.
- coeff_o  out  25*COEFF_W  active taps; tap k is at [k*COEFF_W +: COEFF_W], row-major, k = 5*row + col.
- shift_o  out  SHIFT_W  active output shift.
- commit_pending_o  out  1  a commit is armed and waiting for a frame start.

## Operation
- Register map, by word offset:
  - 0x00..0x60: shadow taps 0..24.
  - 0x64: shadow shift, bits [SHIFT_W-1:0].
  - 0x68: CTRL. Writing bit0 = 1 arms a commit; writing 0 has no effect.
  - Any other address: SLVERR, and no state changes.
- Byte lanes: lane i with wstrb[i] = 1 updates bits [8i+7:8i] of the field. Bits beyond the field width are discarded. CTRL bit0 needs wstrb[0] = 1 to take effect.
- The AW and W channels are accepted independently, each into a one-entry holding register with a full flag.
  - awready = !aw_full && !bvalid.
  - wready = !w_full && !bvalid.
- States:
  - IDLE: collecting AW and W.
  - RESP: bvalid = 1.
  - IDLE -> RESP when both holding registers are full, or will be full at the current edge. On that edge the write is performed, bresp is set, and both full flags are cleared.
  - RESP -> IDLE on bvalid && bready.
- Commit:
  - On frame_start_i with commit_pending set: the active taps and shift take the shadow values sampled before the edge, and commit_pending clears.
  - frame_start_i without a pending commit changes nothing.
- Reset (rstn low, asynchronous):
  - Shadow and active banks hold identity: tap 12 = 1<<SHIFT_RST, all other taps = 0; shift = SHIFT_RST.
  - awready = 0, wready = 0, bvalid = 0, bresp = 0, commit_pending_o = 0, holding flags cleared.
  - awready and wready go to 1 on the first clk edge after rstn is released.
- Reset asserted mid-transaction drops the transaction with no response. The CPU side is reset by the same rstn.

## Timing
- AW and W both valid in cycle T while ready: registers update at the T edge, and bvalid = 1 from T+1.
- AW in cycle T, W in cycle T+n: the write happens at the T+n edge, and bvalid = 1 from T+n+1.
- While bvalid = 1, no new AW or W is accepted. With bready tied high, back-to-back writes sustain one write every 2 cycles.
- CTRL commit write at edge T and frame_start_i sampled at edge T: commit_pending_o becomes 1, and the active bank is unchanged until the next frame_start_i.
- Shadow-tap write and frame_start_i on the same edge with commit pending: the active bank gets the pre-write shadow value. The new value needs another commit.
- Active outputs change only on frame_start_i edges and on reset. They are registered, with no combinational path from the AXI inputs.

## Test plan
- Reset: release rstn -> coeff_o tap 12 = 256, all other taps 0, shift_o = 8, bvalid = 0, commit_pending_o = 0.
- Write 0x0000FFFF to 0x00 with wstrb 4'hF, AW and W in the same cycle -> bvalid the next cycle with bresp 00. coeff_o tap 0 stays 0 until CTRL is written with 1 and frame_start_i pulses; then tap 0 = 16'hFFFF (-1).
- AW sent 3 cycles before W at address 0x64, data 5 -> awready low after the AW handshake until the response completes. One response with bresp 00 after the W handshake. shift_o = 5 after a commit and frame start.
- Write 0x1234 to 0x04 with wstrb 4'h2, starting from shadow tap 1 = 0 -> after a commit, tap 1 = 0x1200.
- Write to address 0x6C -> bresp 10, and shadow, active and pending state are all unchanged.
- Hold bready low for 5 cycles -> bvalid stays high, and awready and wready stay low throughout. Assert rstn low during RESP -> bvalid goes to 0 immediately and the identity bank is restored.

Source files
------------

// File: rtl/fir_coeff_axil_slave.sv
// AXI4-Lite write-only register slave holding a double-buffered 5x5 FIR tap set plus output
// shift; a committed shadow bank is copied to the active bank only on a frame start.
module fir_coeff_axil_slave #(
  parameter int unsigned COEFF_W   = 16,
  parameter int unsigned SHIFT_W   = 5,
  parameter int unsigned SHIFT_RST = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [31:0]            s_axi_awaddr,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [31:0]            s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic                   frame_start_i,
  output logic [25*COEFF_W-1:0]  coeff_o,
  output logic [SHIFT_W-1:0]     shift_o,
  output logic                   commit_pending_o
);

  localparam int unsigned NumTaps = 25;
  localparam int unsigned TapsW   = NumTaps * COEFF_W;
  localparam logic [TapsW-1:0] IdentTaps =
      {{(TapsW - 1){1'b0}}, 1'b1} << (12 * COEFF_W + SHIFT_RST);
  localparam logic [SHIFT_W-1:0] ShiftRst = SHIFT_W'(SHIFT_RST);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e       state_q;
  logic         awready_q, wready_q, bvalid_q;
  logic [1:0]   bresp_q;
  logic         aw_full_q, w_full_q;
  logic [29:0]  aw_word_q;
  logic [31:0]  w_data_q;
  logic [3:0]   w_strb_q;

  logic [TapsW-1:0]   shadow_taps_q, active_taps_q;
  logic [SHIFT_W-1:0] shadow_shift_q, active_shift_q;
  logic               pending_q;

  logic               aw_hs, w_hs, fire;
  logic [29:0]        wr_word;
  logic [31:0]        wr_data;
  logic [3:0]         wr_strb;
  logic               is_tap, is_shift, is_ctrl, addr_ok;
  int unsigned        tap_idx;
  logic [COEFF_W-1:0] tap_old;
  logic               arm, commit;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^s_axi_awaddr[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  // A channel counts as present if already held or handshaking on this edge.
  always_comb begin
    aw_hs    = s_axi_awvalid && awready_q;
    w_hs     = s_axi_wvalid && wready_q;
    fire     = (state_q == StIdle) && (aw_full_q || aw_hs) && (w_full_q || w_hs);
    wr_word  = aw_full_q ? aw_word_q : s_axi_awaddr[31:2];
    wr_data  = w_full_q ? w_data_q : s_axi_wdata;
    wr_strb  = w_full_q ? w_strb_q : s_axi_wstrb;
    is_tap   = wr_word < 30'd25;
    is_shift = wr_word == 30'd25;
    is_ctrl  = wr_word == 30'd26;
    addr_ok  = is_tap || is_shift || is_ctrl;
    tap_idx  = is_tap ? 32'(wr_word[4:0]) : 32'd0;
    tap_old  = shadow_taps_q[tap_idx*COEFF_W +: COEFF_W];
    arm      = fire && is_ctrl && wr_strb[0] && wr_data[0];
    commit   = frame_start_i && pending_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_word_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fire) begin
            state_q   <= StResp;
            bvalid_q  <= 1'b1;
            bresp_q   <= addr_ok ? RespOkay : RespSlverr;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_full_q <= 1'b1;
              aw_word_q <= s_axi_awaddr[31:2];
              awready_q <= 1'b0;
            end else begin
              awready_q <= !aw_full_q;
            end
            if (w_hs) begin
              w_full_q  <= 1'b1;
              w_data_q  <= s_axi_wdata;
              w_strb_q  <= s_axi_wstrb;
              wready_q  <= 1'b0;
            end else begin
              wready_q  <= !w_full_q;
            end
          end
        end
        StResp: begin
          if (s_axi_bready) begin
            state_q   <= StIdle;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Commit copies the pre-edge shadow, so a same-edge shadow write lands only in the shadow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_taps_q  <= IdentTaps;
      active_taps_q  <= IdentTaps;
      shadow_shift_q <= ShiftRst;
      active_shift_q <= ShiftRst;
      pending_q      <= 1'b0;
    end else begin
      if (fire && is_tap) begin
        shadow_taps_q[tap_idx*COEFF_W +: COEFF_W] <=
            COEFF_W'(merge_bytes(32'(tap_old), wr_data, wr_strb));
      end
      if (fire && is_shift) begin
        shadow_shift_q <= SHIFT_W'(merge_bytes(32'(shadow_shift_q), wr_data, wr_strb));
      end
      if (commit) begin
        active_taps_q  <= shadow_taps_q;
        active_shift_q <= shadow_shift_q;
      end
      if (arm) begin
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign s_axi_awready    = awready_q;
  assign s_axi_wready     = wready_q;
  assign s_axi_bvalid     = bvalid_q;
  assign s_axi_bresp      = bresp_q;
  assign coeff_o          = active_taps_q;
  assign shift_o          = active_shift_q;
  assign commit_pending_o = pending_q;

endmodule

// File: tb/tb_fir_coeff_axil_slave.sv
// Directed bench for fir_coeff_axil_slave: response scoreboard plus a shadow/active bank model.
module tb_fir_coeff_axil_slave;

  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  s_axi_awaddr;
  logic         s_axi_awvalid;
  logic         s_axi_awready;
  logic [31:0]  s_axi_wdata;
  logic [3:0]   s_axi_wstrb;
  logic         s_axi_wvalid;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready;
  logic         frame_start_i;
  logic [399:0] coeff_o;
  logic [4:0]   shift_o;
  logic         commit_pending_o;

  fir_coeff_axil_slave dut (
    .clk              (clk),
    .rstn             (rstn),
    .s_axi_awaddr     (s_axi_awaddr),
    .s_axi_awvalid    (s_axi_awvalid),
    .s_axi_awready    (s_axi_awready),
    .s_axi_wdata      (s_axi_wdata),
    .s_axi_wstrb      (s_axi_wstrb),
    .s_axi_wvalid     (s_axi_wvalid),
    .s_axi_wready     (s_axi_wready),
    .s_axi_bresp      (s_axi_bresp),
    .s_axi_bvalid     (s_axi_bvalid),
    .s_axi_bready     (s_axi_bready),
    .frame_start_i    (frame_start_i),
    .coeff_o          (coeff_o),
    .shift_o          (shift_o),
    .commit_pending_o (commit_pending_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0]  exp_q[$];
  logic [15:0] sh_taps[25];
  logic [15:0] act_taps[25];
  logic [4:0]  sh_shift, act_shift;
  bit          pending;

  task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 25; k++) begin
      sh_taps[k]  = 16'h0000;
      act_taps[k] = 16'h0000;
    end
    sh_taps[12]  = 16'h0100;
    act_taps[12] = 16'h0100;
    sh_shift     = 5'd8;
    act_shift    = 5'd8;
    pending      = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_frame();
    if (pending) begin
      for (int k = 0; k < 25; k++) act_taps[k] = sh_taps[k];
      act_shift = sh_shift;
      pending   = 1'b0;
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    logic [31:0] word;
    logic [31:0] v;
    word = {2'b00, addr[31:2]};
    if (word < 25) begin
      v = {16'h0000, sh_taps[word]};
      for (int i = 0; i < 4; i++) if (strb[i]) v[8*i +: 8] = data[8*i +: 8];
      sh_taps[word] = v[15:0];
    end else if (word == 25) begin
      v = {27'd0, sh_shift};
      for (int i = 0; i < 4; i++) if (strb[i]) v[8*i +: 8] = data[8*i +: 8];
      sh_shift = v[4:0];
    end else if (word == 26) begin
      if (strb[0] && data[0]) pending = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [399:0] exp_vec;
    for (int k = 0; k < 25; k++) exp_vec[k*16 +: 16] = act_taps[k];
    chk({tag, ".coeff"}, coeff_o, exp_vec);
    chk({tag, ".shift"}, 400'(shift_o), 400'(act_shift));
    chk({tag, ".pending"}, 400'(commit_pending_o), 400'(pending));
  endtask

  // Drives AW now and W after w_delay cycles; returns at the negedge where bvalid should be up.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_delay, input bit fs_on_fire);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_acc, w_acc, fs_now;
    int cyc = 0;
    exp_q.push_back((addr[31:2] <= 30'd26) ? 2'b00 : 2'b10);
    @(posedge clk); #1;
    s_axi_awaddr  = addr;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (cyc == w_delay) s_axi_wvalid = 1'b1;
      @(negedge clk);
      if (aw_done) chk("awready_low_while_held", 400'(s_axi_awready), 400'(0));
      aw_acc = s_axi_awvalid && s_axi_awready;
      w_acc  = s_axi_wvalid && s_axi_wready;
      fs_now = fs_on_fire && (aw_done || aw_acc) && (w_done || w_acc);
      if (fs_now) frame_start_i = 1'b1;
      @(posedge clk); #1;
      frame_start_i = 1'b0;
      if (aw_acc) begin s_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_acc)  begin s_axi_wvalid  = 1'b0; w_done  = 1'b1; end
      if (fs_now) model_frame();
      cyc++;
    end
    chk("handshakes_done", 400'({aw_done, w_done}), 400'(2'b11));
    if (exp_q[$] == 2'b00) model_write(addr, data, strb);
    @(negedge clk);
    chk("bvalid_next_cycle", 400'(s_axi_bvalid), 400'(1));
  endtask

  task automatic finish_resp(input int hold);
    logic [1:0] exp_resp;
    s_axi_bready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("bvalid_held", 400'(s_axi_bvalid), 400'(1));
      chk("awready_low_in_resp", 400'(s_axi_awready), 400'(0));
      chk("wready_low_in_resp", 400'(s_axi_wready), 400'(0));
      @(negedge clk);
    end
    chk("bvalid_before_ready", 400'(s_axi_bvalid), 400'(1));
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 400'(exp_q.size()), 400'(1));
    end else begin
      exp_resp = exp_q.pop_front();
      chk("bresp", 400'(s_axi_bresp), 400'(exp_resp));
    end
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    @(negedge clk);
    chk("bvalid_cleared", 400'(s_axi_bvalid), 400'(0));
    chk("awready_after_resp", 400'(s_axi_awready), 400'(1));
  endtask

  task automatic pulse_frame();
    @(posedge clk); #1;
    frame_start_i = 1'b1;
    @(posedge clk); #1;
    frame_start_i = 1'b0;
    model_frame();
  endtask

  task automatic commit(input string tag);
    do_write(32'h68, 32'h1, 4'hF, 0, 1'b0);
    finish_resp(0);
    check_all({tag, ".armed"});
    pulse_frame();
    check_all({tag, ".committed"});
  endtask

  initial begin
    rstn          = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    frame_start_i = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("awready_in_reset_release", 400'(s_axi_awready), 400'(0));
    chk("wready_in_reset_release", 400'(s_axi_wready), 400'(0));
    chk("bvalid_reset", 400'(s_axi_bvalid), 400'(0));
    check_all("reset");
    @(posedge clk); #1;
    chk("awready_first_edge", 400'(s_axi_awready), 400'(1));
    chk("wready_first_edge", 400'(s_axi_wready), 400'(1));

    // Full-word tap 0, same-cycle AW/W; active bank must wait for commit.
    do_write(32'h00, 32'h0000FFFF, 4'hF, 0, 1'b0);
    finish_resp(0);
    check_all("tap0_shadow_only");
    pulse_frame();
    check_all("frame_without_commit");
    commit("tap0");

    // AW three cycles ahead of W, shift register.
    do_write(32'h64, 32'd5, 4'hF, 3, 1'b0);
    finish_resp(0);
    commit("shift5");

    // Single byte lane 1 into tap 1.
    do_write(32'h04, 32'h00001234, 4'h2, 0, 1'b0);
    finish_resp(0);
    commit("tap1_lane1");

    // Unmapped address while a commit is armed.
    do_write(32'h68, 32'h1, 4'hF, 0, 1'b0);
    finish_resp(0);
    do_write(32'h6C, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
    finish_resp(0);
    check_all("slverr_no_change");
    do_write(32'h00000100, 32'hFFFFFFFF, 4'hF, 1, 1'b0);
    finish_resp(0);
    pulse_frame();
    check_all("slverr_then_commit");

    // CTRL lane 0 disabled: no arm.
    do_write(32'h68, 32'h1, 4'hE, 0, 1'b0);
    finish_resp(0);
    check_all("ctrl_no_lane0");

    // CTRL write and frame start on the same edge: armed, active unchanged.
    do_write(32'h08, 32'h00004321, 4'hF, 0, 1'b0);
    finish_resp(0);
    do_write(32'h68, 32'h1, 4'hF, 0, 1'b1);
    finish_resp(0);
    check_all("ctrl_same_edge_frame");

    // Shadow write on the commit edge: active gets the pre-write value.
    do_write(32'h14, 32'h00000077, 4'hF, 2, 1'b1);
    finish_resp(0);
    check_all("write_on_commit_edge");
    commit("tap5_late");

    // Back-pressured response.
    do_write(32'h30, 32'h0000ABCD, 4'h3, 0, 1'b0);
    finish_resp(5);
    commit("tap12_bp");

    // Reset in the middle of a response.
    do_write(32'h0C, 32'h00000055, 4'hF, 0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("bvalid_async_reset", 400'(s_axi_bvalid), 400'(0));
    chk("awready_async_reset", 400'(s_axi_awready), 400'(0));
    check_all("async_reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("awready_after_rerelease", 400'(s_axi_awready), 400'(1));
    commit("identity_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
